// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  // Widest operand the generic helpers handle; callers cast in and out.
  localparam int MAXW = 64;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic logic [MAXW-1:0] twos_neg(input logic [MAXW-1:0] v);
    return ~v + MAXW'(1);
  endfunction

  function automatic logic [MAXW-1:0] cond_neg(input logic [MAXW-1:0] v, input logic en);
    return en ? twos_neg(v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  logic [WIDTH+1:0] w_shift;

  assign w_shift = {i_rem, i_bit};
  assign o_qbit  = (w_shift >= {2'b00, i_dvs});
  assign o_rem   = o_qbit ? (w_shift[WIDTH:0] - {1'b0, i_dvs}) : w_shift[WIDTH:0];

endmodule

// File: rtl/div_int_seq.sv
// Multi-cycle restoring divider with signed/unsigned mode, divide-by-zero flag
// and valid/ready handshakes; one division in flight at a time.
module div_int_seq
  import div_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dvs,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] qot,
  output logic [WIDTH-1:0] rmd,
  output logic             div_zero
);

  localparam int CW = clog2(WIDTH + 1);

  div_state_t       r_state;
  div_state_t       w_state_next;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_count;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_qot;
  logic [WIDTH-1:0] r_rmd;
  logic             r_div_zero;

  logic             w_signed;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_rem_next;
  logic             w_qbit;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_qot_fix;
  logic [WIDTH-1:0] w_rmd_fix;

  assign w_signed  = sgn & SIGNED_EN;
  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_last    = (r_count == CW'(WIDTH - 1));
  // Most-negative input maps to 2^(WIDTH-1), still representable unsigned.
  assign w_dvd_mag = WIDTH'(cond_neg(MAXW'(dvd), w_signed & dvd[WIDTH-1]));
  assign w_dvs_mag = WIDTH'(cond_neg(MAXW'(dvs), w_signed & dvs[WIDTH-1]));

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_quo[WIDTH-1]),
    .i_dvs  (r_dvs),
    .o_rem  (w_rem_next),
    .o_qbit (w_qbit)
  );

  assign w_quo_next = {r_quo[WIDTH-2:0], w_qbit};
  assign w_qot_fix  = WIDTH'(cond_neg(MAXW'(w_quo_next), r_neg_q));
  assign w_rmd_fix  = WIDTH'(cond_neg(MAXW'(w_rem_next[WIDTH-1:0]), r_neg_r));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = (dvs == '0) ? DONE : CALC;
      end
      CALC: if (w_last) w_state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Divisor zero short-circuits straight to a result; otherwise load magnitudes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_count    <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_qot      <= '0;
      r_rmd      <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      if (dvs == '0) begin
        r_qot      <= '1;
        r_rmd      <= dvd;
        r_div_zero <= 1'b1;
      end else begin
        r_rem   <= '0;
        r_quo   <= w_dvd_mag;
        r_dvs   <= w_dvs_mag;
        r_count <= '0;
        r_neg_q <= w_signed & (dvd[WIDTH-1] ^ dvs[WIDTH-1]);
        r_neg_r <= w_signed & dvd[WIDTH-1];
      end
    end else if (r_state == CALC) begin
      r_rem   <= w_rem_next;
      r_quo   <= w_quo_next;
      r_count <= r_count + CW'(1);
      if (w_last) begin
        r_qot      <= w_qot_fix;
        r_rmd      <= w_rmd_fix;
        r_div_zero <= 1'b0;
      end
    end
  end

  assign qot      = r_qot;
  assign rmd      = r_rmd;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_div_int_seq.sv
// Directed bench for div_int_seq: arithmetic model + scoreboard, plus literal checks.
module tb_div_int_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         sgn = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] dvd = '0;
  logic [W-1:0] dvs = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] qot;
  logic [W-1:0] rmd;
  logic         div_zero;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } res_t;

  res_t exp_q[$];

  always #5 clk = ~clk;

  div_int_seq #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dvd       (dvd),
    .dvs       (dvs),
    .sgn       (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .qot       (qot),
    .rmd       (rmd),
    .div_zero  (div_zero)
  );

  // Integer arithmetic: '/' and '%' on ints truncate toward zero, remainder follows dividend.
  function automatic res_t model(input logic [W-1:0] a_in, input logic [W-1:0] b_in, input logic s);
    res_t res;
    int a, b, q, r;
    if (b_in == '0) begin
      res.q  = '1;
      res.r  = a_in;
      res.dz = 1'b1;
      return res;
    end
    if (s) begin
      a = $signed(a_in);
      b = $signed(b_in);
    end else begin
      a = int'(a_in);
      b = int'(b_in);
    end
    q = a / b;
    r = a % b;
    res.q  = q[W-1:0];
    res.r  = r[W-1:0];
    res.dz = 1'b0;
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: push at accept, compare every cycle a result is presented.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      chk("hs_exclusive", 32'(in_ready & out_valid), 32'd0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          chk("sb_qot", 32'(qot), 32'(exp_q[0].q));
          chk("sb_rmd", 32'(rmd), 32'(exp_q[0].r));
          chk("sb_div_zero", 32'(div_zero), 32'(exp_q[0].dz));
          if (out_ready) begin
            $display("[TB] result qot=%02h rmd=%02h div_zero=%0d", qot, rmd, div_zero);
            void'(exp_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(dvd, dvs, sgn));
    end
  end

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid) chk("in_ready_busy", 32'(in_ready), 32'd0);
    end while (!out_valid && lat < 40);
    chk("result_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int guard;
    guard = 0;
    @(posedge clk); #2;
    in_valid = 1'b1; dvd = a; dvs = b; sgn = s;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #2;
    // Scramble operands after accept: they must be ignored.
    in_valid = 1'b0; dvd = ~a; dvs = 8'h01; sgn = ~s;
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                    input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez, input int elat);
    int lat;
    send(a, b, s);
    wait_valid(lat);
    chk("latency", 32'(lat), 32'(elat));
    chk("lit_qot", 32'(qot), 32'(eq));
    chk("lit_rmd", 32'(rmd), 32'(er));
    chk("lit_div_zero", 32'(div_zero), 32'(ez));
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_qot", 32'(qot), 32'd0);
    chk("rst_rmd", 32'(rmd), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    op(8'd100, 8'd10, 1'b0, 8'd10,  8'd0,  1'b0, 9);
    op(8'd255, 8'd5,  1'b0, 8'd51,  8'd0,  1'b0, 9);
    op(8'hF9,  8'h02, 1'b1, 8'hFD,  8'hFF, 1'b0, 9);
    op(8'h07,  8'hFE, 1'b1, 8'hFD,  8'h01, 1'b0, 9);
    op(8'h80,  8'hFF, 1'b1, 8'h80,  8'h00, 1'b0, 9);
    op(8'h80,  8'hFF, 1'b0, 8'h00,  8'h80, 1'b0, 9);
    op(8'd67,  8'd0,  1'b0, 8'hFF,  8'd67, 1'b1, 1);

    // Back-to-back with in_valid held high; second operands wait out the first op.
    @(posedge clk); #2;
    in_valid = 1'b1; dvd = 8'd67; dvs = 8'd20; sgn = 1'b0;
    @(negedge clk);
    chk("b2b_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #2;
    dvd = 8'd16; dvs = 8'd3;
    wait_valid(lat);
    chk("b2b1_latency", 32'(lat), 32'd9);
    chk("b2b1_qot", 32'(qot), 32'd3);
    chk("b2b1_rmd", 32'(rmd), 32'd7);
    chk("b2b1_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("b2b_gap_out_valid", 32'(out_valid), 32'd0);
    chk("b2b_gap_in_ready", 32'(in_ready), 32'd1);
    wait_valid(lat);
    #1 in_valid = 1'b0;
    chk("b2b2_latency", 32'(lat), 32'd9);
    chk("b2b2_qot", 32'(qot), 32'd5);
    chk("b2b2_rmd", 32'(rmd), 32'd1);

    // Back-pressure: result held for 5 cycles then retained after consumption.
    @(posedge clk); #2;
    out_ready = 1'b0;
    send(8'd200, 8'd7, 1'b0);
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'd9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_qot", 32'(qot), 32'd28);
      chk("bp_rmd", 32'(rmd), 32'd4);
      chk("bp_div_zero", 32'(div_zero), 32'd0);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_consume_out_valid", 32'(out_valid), 32'd0);
    chk("retain_qot", 32'(qot), 32'd28);
    chk("retain_rmd", 32'(rmd), 32'd4);

    // Reset on the 3rd CALC cycle discards the operation.
    send(8'd100, 8'd7, 1'b0);
    @(posedge clk);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_qot", 32'(qot), 32'd0);
    chk("midrst_rmd", 32'(rmd), 32'd0);
    chk("midrst_div_zero", 32'(div_zero), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("midrst_no_result", 32'(out_valid), 32'd0);
    end

    op(8'h81, 8'h03, 1'b1, 8'hD6, 8'hFF, 1'b0, 9);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
